// File: rtl/aes_pkg.sv
// Shared types and constant tables for the AES key-schedule controller.
package aes_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Byte 0x00 sits in the leftmost position, hence the ~b lookup below.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Index 0 and 11..15 are never used by a legal schedule and read as zero.
  localparam logic [15:0][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return RCON[~idx];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups, purely combinational.
module aes_subword
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-expansion controller: one schedule word per cycle into a round-key store,
// then registered 128-bit round-key reads.
//   state     | meaning
//   ST_IDLE   | no schedule yet since reset
//   ST_EXPAND | generating w[r_cnt] each cycle
//   ST_READY  | store complete, reads served
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_ready,
  input  logic         rd_req,
  input  logic [3:0]   rd_idx,
  output logic         rk_valid,
  output logic [127:0] rk
);

  localparam int         NW        = 4 * (Nr + 1);
  localparam logic [5:0] LAST_WORD = 6'(NW - 1);
  localparam logic [2:0] KPOS_LAST = 3'(Nk - 1);

  state_t       r_state, w_state_nxt;
  logic [5:0]   r_cnt;
  logic [2:0]   r_kpos;
  logic [3:0]   r_rc_idx;
  word_t        r_store [NW];
  logic         r_done, r_key_ready, r_rk_valid;
  logic [127:0] r_rk;

  logic       w_accept, w_last, w_rd_ok;
  word_t      w_prev, w_back, w_sub_in, w_sub_out, w_temp, w_new;
  logic [5:0] w_base;

  assign w_accept = start && (r_state != ST_EXPAND);
  assign w_last   = (r_state == ST_EXPAND) && (r_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)    w_state_nxt = ST_EXPAND;
    else if (w_last) w_state_nxt = ST_READY;
  end

  assign w_prev   = r_store[r_cnt - 6'd1];
  assign w_back   = r_store[r_cnt - 6'(Nk)];
  assign w_sub_in = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_kpos == 3'd0)                 w_temp = w_sub_out ^ {rcon(r_rc_idx), 24'h0};
    else if (Nk == 8 && r_kpos == 3'd4) w_temp = w_sub_out;
  end

  assign w_new = w_back ^ w_temp;

  // Control and read-side registers; r_kpos/r_rc_idx track i mod Nk and i/Nk without a divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_kpos      <= '0;
      r_rc_idx    <= '0;
      r_done      <= 1'b0;
      r_key_ready <= 1'b0;
      r_rk_valid  <= 1'b0;
      r_rk        <= '0;
    end else begin
      r_done     <= w_last;
      r_rk_valid <= w_rd_ok;
      if (w_rd_ok)
        r_rk <= {r_store[w_base], r_store[w_base + 6'd1],
                 r_store[w_base + 6'd2], r_store[w_base + 6'd3]};
      if (w_accept) begin
        r_key_ready <= 1'b0;
        r_cnt       <= 6'(Nk);
        r_kpos      <= '0;
        r_rc_idx    <= 4'd1;
      end else if (r_state == ST_EXPAND) begin
        r_cnt <= r_cnt + 6'd1;
        if (r_kpos == KPOS_LAST) begin
          r_kpos   <= '0;
          r_rc_idx <= r_rc_idx + 4'd1;
        end else begin
          r_kpos <= r_kpos + 3'd1;
        end
        if (w_last) r_key_ready <= 1'b1;
      end
    end
  end

  // The store is not reset: key_ready gates every read of stale contents.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < Nk; k++) r_store[k] <= key_in[N-1-32*k -: 32];
    end else if (r_state == ST_EXPAND) begin
      r_store[r_cnt] <= w_new;
    end
  end

  assign w_base  = {rd_idx, 2'b00};
  assign w_rd_ok = rd_req && r_key_ready && !w_accept && (rd_idx <= 4'(Nr));

  assign busy      = (r_state == ST_EXPAND);
  assign done      = r_done;
  assign key_ready = r_key_ready;
  assign rk_valid  = r_rk_valid;
  assign rk        = r_rk;

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 128, giving the cipher key width in bits (128, 192 or 256).
REQ-002 The block SHALL have parameter Nr, default 10, giving the round count (10, 12 or 14).
REQ-003 The block SHALL have parameter Nk, default 4, giving the key length in words (4, 6 or 8).
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: request to expand the key present on key_in.
REQ-007 Port key_in, input, N bits: cipher key, word 0 in the MSBs; sampled only when start is accepted.
REQ-008 Port busy, output, 1 bit: expansion in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when expansion completes.
REQ-010 Port key_ready, output, 1 bit: the round-key store holds a valid schedule.
REQ-011 Port rd_req, input, 1 bit: round-key read request.
REQ-012 Port rd_idx, input, 4 bits: index of the round key to read, 0..Nr.
REQ-013 Port rk_valid, output, 1 bit: rk holds the requested round key.
REQ-014 Port rk, output, 128 bits: round key, word 4*rd_idx in the MSBs.

Function
REQ-015 The FSM SHALL have three states: IDLE, EXPAND, READY.
REQ-016 start in IDLE or READY SHALL be accepted: Nk key words written to store[0..Nk-1], key_ready cleared, word counter i=Nk, next state EXPAND.
REQ-017 start in EXPAND SHALL be ignored, with no effect on key_in sampling or progress.
REQ-018 In EXPAND, exactly one word w[i] SHALL be produced per cycle, as w[i] = w[i-Nk] XOR temp.
REQ-019 temp SHALL be w[i-1], except:
  - i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) XOR Rcon[i/Nk].
  - Nk=8 and i mod Nk = 4: temp = SubWord(w[i-1]).
REQ-020 Rcon SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte, zero elsewhere.
REQ-021 After writing word 4*(Nr+1)-1, the FSM SHALL enter READY, pulse done for one cycle and set key_ready.
REQ-022 Latency: done SHALL assert on cycle 4*(Nr+1)-Nk+1 after the accepting edge (41 for AES-128, 47 for AES-192, 53 for AES-256).
REQ-023 busy SHALL be 1 exactly while the state is EXPAND.
REQ-024 Reads: rd_req with key_ready=1 and rd_idx<=Nr SHALL give rk_valid=1 with rk=store[4*rd_idx..4*rd_idx+3] on the next cycle (registered, 1-cycle latency).
REQ-025 rd_req with key_ready=0 or rd_idx>Nr SHALL give rk_valid=0 next cycle; rk SHALL keep its prior value.
REQ-026 rd_req in the same cycle as an accepted start SHALL be treated as key_ready=0.
REQ-027 Back-to-back reads SHALL be supported at one per cycle.

Reset
REQ-028 On rst_n low, all of the following SHALL hold, independent of clk: state=IDLE, busy=0, done=0, key_ready=0, rk_valid=0, rk=0, counter=0.
REQ-029 Reset mid-EXPAND SHALL abandon the schedule; store contents need not be cleared, but key_ready SHALL stay 0 until a new expansion completes.

Structure
REQ-030 A shared package aes_pkg SHALL hold the S-box table, the Rcon table, the word-type typedef and the FSM state enum.
REQ-031 One sub-module aes_subword (four parallel S-box lookups, combinational) SHALL be instantiated once, since only one word is generated per cycle.
REQ-032 The store SHALL be a 4*(Nr+1) x 32 register array; no other datapath SHALL be duplicated.

Verification
REQ-033 Scenario AES-128 vector: start with key 2b7e151628aed2a6abf7158809cf4f3c -> done at cycle 41; rd_idx=1 -> rk=a0fafe1788542cb123a339392a6c7605; rd_idx=10 -> rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-034 Scenario AES-256 (Nk=8, Nr=14): key 000102...1e1f -> done at cycle 53; rd_idx=14 -> rk=24fc79ccbf0979e9371ac23c6d68de36.
REQ-035 Scenario start during EXPAND: a second start with a different key at cycle 10 -> ignored; results identical to REQ-033.
REQ-036 Scenario read gating: rd_req during EXPAND, or rd_idx=11 while READY -> rk_valid=0 and rk unchanged.
REQ-037 Scenario reset: rst_n low at cycle 20 of expansion -> all outputs 0 immediately; a fresh start then yields the REQ-033 results.
REQ-038 Scenario re-key from READY: start with the all-zero key -> key_ready drops the next cycle; done follows 41 cycles later; rd_idx=10 -> rk=b4ef5bcb3e92e21123e951cf6f8f188e.
